time_set_ctrl: RTL and testbench

Time-setting controller for the real-time clock. It converts three push-buttons (mode, increment, decrement) into the `load`/`addrs`/`data_in` write sequence accepted by the seconds, minutes and hours counters. It sits beside the clock top level, reads back the live counter values to seed each edit, and drives a blink strobe and field indicator for the display.

---
 rtl/clk_pkg.sv | 37 +++
 rtl/btn_sync_edge.sv | 38 +++
 rtl/time_set_ctrl.sv | 145 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared definitions for the RTC time-setting path: counter addresses,
// field limits, controller state encoding and the wrap helper.
package clk_pkg;

  localparam logic [1:0] ADDR_SEC  = 2'b00;
  localparam logic [1:0] ADDR_MIN  = 2'b01;
  localparam logic [1:0] ADDR_HR   = 2'b10;
  localparam logic [1:0] ADDR_NONE = 2'b11;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_HR  = 6'd23;

  typedef enum logic [1:0] {
    RUN,
    ED_HR,
    ED_MIN,
    ED_SEC
  } state_t;

  function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                           input logic [5:0] maxv,
                                           input logic       up);
    if (up) return (v >= maxv) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? maxv : v - 6'd1;
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      ED_HR:   return ADDR_HR;
      ED_MIN:  return ADDR_MIN;
      ED_SEC:  return ADDR_SEC;
      default: return ADDR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse for one raw button.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_v1;
  logic r_armed;
  logic r_pulse;

  // Edges are only honoured once the button has been seen low after reset,
  // so a button held through reset release never yields an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_v1    <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_v1    <= 1'b1;
      r_armed <= r_v1 & (r_armed | ~r_s1);
      r_pulse <= r_s2 & ~r_s3 & r_armed;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: turns mode/inc/dec buttons into one-cycle
// load/addrs/data_in writes to the seconds, minutes and hours counters.
module time_set_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tc_time_base,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] q_seconds,
  input  logic [5:0] q_minutes,
  input  logic [4:0] q_hours,
  output logic       load,
  output logic [1:0] addrs,
  output logic [5:0] data_in,
  output logic [1:0] edit_field,
  output logic [5:0] edit_value,
  output logic       blink
);

  localparam int unsigned TW = ($clog2(TIMEOUT_S + 1) < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S);

  logic w_mode;
  logic w_inc;
  logic w_dec;
  logic w_any;

  btn_sync_edge u_mode (.clk(clk), .reset(reset), .i_btn(btn_mode), .o_pulse(w_mode));
  btn_sync_edge u_inc  (.clk(clk), .reset(reset), .i_btn(btn_inc),  .o_pulse(w_inc));
  btn_sync_edge u_dec  (.clk(clk), .reset(reset), .i_btn(btn_dec),  .o_pulse(w_dec));

  assign w_any = w_mode | w_inc | w_dec;

  state_t        r_state;
  logic          r_load;
  logic [1:0]    r_addrs;
  logic [5:0]    r_data;
  logic [1:0]    r_field;
  logic [5:0]    r_value;
  logic          r_blink;
  logic [TW-1:0] r_to;

  state_t        w_state_nxt;
  logic          w_load_nxt;
  logic [1:0]    w_addrs_nxt;
  logic [5:0]    w_data_nxt;
  logic [1:0]    w_field_nxt;
  logic [5:0]    w_value_nxt;
  logic          w_blink_nxt;
  logic [TW-1:0] w_to_nxt;
  logic [TW-1:0] w_to_inc;
  logic [5:0]    w_fmax;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_load  <= 1'b0;
      r_addrs <= ADDR_SEC;
      r_data  <= '0;
      r_field <= ADDR_NONE;
      r_value <= '0;
      r_blink <= 1'b0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= w_load_nxt;
      r_addrs <= w_addrs_nxt;
      r_data  <= w_data_nxt;
      r_field <= w_field_nxt;
      r_value <= w_value_nxt;
      r_blink <= w_blink_nxt;
      r_to    <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = 1'b0;
    w_addrs_nxt = r_addrs;
    w_data_nxt  = r_data;
    w_value_nxt = r_value;
    w_blink_nxt = r_blink;
    w_to_nxt    = r_to;
    w_to_inc    = r_to + TW'(1);
    w_fmax      = (r_state == ED_HR)  ? MAX_HR :
                  (r_state == ED_MIN) ? MAX_MIN : MAX_SEC;

    case (r_state)
      RUN: begin
        if (w_mode) begin
          w_state_nxt = ED_HR;
          w_value_nxt = {1'b0, q_hours};
        end
      end
      default: begin
        if (w_mode) begin
          w_load_nxt  = 1'b1;
          w_addrs_nxt = field_of(r_state);
          w_data_nxt  = r_value;
          case (r_state)
            ED_HR: begin
              w_state_nxt = ED_MIN;
              w_value_nxt = q_minutes;
            end
            ED_MIN: begin
              w_state_nxt = ED_SEC;
              w_value_nxt = q_seconds;
            end
            default: w_state_nxt = RUN;
          endcase
        end else begin
          if (w_inc ^ w_dec) w_value_nxt = wrap_step(r_value, w_fmax, w_inc);
          if (tc_time_base && !w_any && (w_to_inc == TO_LAST)) w_state_nxt = RUN;
        end
      end
    endcase

    // Blink and inactivity count restart on every state change.
    if (w_state_nxt == RUN) begin
      w_blink_nxt = 1'b0;
      w_to_nxt    = '0;
    end else if (w_state_nxt != r_state) begin
      w_blink_nxt = 1'b1;
      w_to_nxt    = '0;
    end else begin
      w_blink_nxt = r_blink ^ tc_time_base;
      w_to_nxt    = w_any ? '0 : (tc_time_base ? w_to_inc : r_to);
    end

    w_field_nxt = field_of(w_state_nxt);
  end

  assign load       = r_load;
  assign addrs      = r_addrs;
  assign data_in    = r_data;
  assign edit_field = r_field;
  assign edit_value = r_value;
  assign blink      = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed and randomized bench for time_set_ctrl against an operation-level model.
module tb_time_set_ctrl;

  localparam int unsigned TO = 3;

  logic       clk;
  logic       reset;
  logic       tc_time_base;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [5:0] q_seconds;
  logic [5:0] q_minutes;
  logic [4:0] q_hours;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic [1:0] edit_field;
  logic [5:0] edit_value;
  logic       blink;

  time_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk(clk), .reset(reset), .tc_time_base(tc_time_base),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .q_seconds(q_seconds), .q_minutes(q_minutes), .q_hours(q_hours),
    .load(load), .addrs(addrs), .data_in(data_in),
    .edit_field(edit_field), .edit_value(edit_value), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] got_w[$];
  logic [7:0] m_w[$];
  int m_field = 3;
  int m_val   = 0;
  int m_blink = 0;
  int m_to    = 0;
  int m_last_addr = 0;
  int m_last_data = 0;

  always @(negedge clk) if (load === 1'b1) got_w.push_back({addrs, data_in});

  initial begin
    #500000;
    $display("FAIL watchdog: observed time limit expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    check({tag, ".field"}, 32'(edit_field), 32'(m_field));
    check({tag, ".blink"}, 32'(blink), 32'(m_blink));
    check({tag, ".load"}, 32'(load), 0);
    if (m_field != 3) check({tag, ".value"}, 32'(edit_value), 32'(m_val));
    check({tag, ".nwrites"}, 32'(got_w.size()), 32'(m_w.size()));
    n = (got_w.size() < m_w.size()) ? got_w.size() : m_w.size();
    for (int k = 0; k < n; k++) check({tag, ".write"}, 32'(got_w[k]), 32'(m_w[k]));
    check({tag, ".addrs"}, 32'(addrs), 32'(m_last_addr));
    check({tag, ".data"}, 32'(data_in), 32'(m_last_data));
    got_w.delete();
    m_w.delete();
  endtask

  function automatic int field_max(input int f);
    return (f == 2) ? 23 : 59;
  endfunction

  task automatic model_btn(input logic m, input logic i, input logic d);
    if (!(m | i | d)) return;
    m_to = 0;
    if (m) begin
      if (m_field == 3) begin
        m_field = 2;
        m_val   = int'(q_hours);
        m_blink = 1;
      end else begin
        m_w.push_back(8'((m_field << 6) | m_val));
        m_last_addr = m_field;
        m_last_data = m_val;
        m_field = m_field - 1;
        if (m_field == 1) m_val = int'(q_minutes);
        if (m_field == 0) m_val = int'(q_seconds);
        if (m_field < 0) m_field = 3;
        m_blink = (m_field == 3) ? 0 : 1;
      end
    end else if (m_field != 3 && (i ^ d)) begin
      if (i) m_val = (m_val + 1) % (field_max(m_field) + 1);
      else   m_val = (m_val + field_max(m_field)) % (field_max(m_field) + 1);
    end
  endtask

  task automatic model_tick();
    if (m_field == 3) return;
    m_to++;
    if (m_to == TO) begin
      m_field = 3;
      m_blink = 0;
      m_to    = 0;
    end else begin
      m_blink ^= 1;
    end
  endtask

  task automatic push_btn(input logic m, input logic i, input logic d, input int hold);
    @(posedge clk); #1;
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (hold) @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    model_btn(m, i, d);
  endtask

  task automatic tick();
    @(posedge clk); #1 tc_time_base = 1'b1;
    @(posedge clk); #1 tc_time_base = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".load"}, 32'(load), 0);
    check({tag, ".addrs"}, 32'(addrs), 0);
    check({tag, ".data"}, 32'(data_in), 0);
    check({tag, ".field"}, 32'(edit_field), 3);
    check({tag, ".value"}, 32'(edit_value), 0);
    check({tag, ".blink"}, 32'(blink), 0);
  endtask

  initial begin
    reset = 1'b0; tc_time_base = 1'b0;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    q_seconds = '0; q_minutes = '0; q_hours = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk);

    // Mode latency: no effect after N+2, edit visible after N+3
    q_hours = 5'd5;
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat.before", 32'(edit_field), 3);
    @(posedge clk);
    @(negedge clk);
    check("lat.field", 32'(edit_field), 2);
    check("lat.value", 32'(edit_value), 5);
    check("lat.blink", 32'(blink), 1);
    check("lat.load", 32'(load), 0);
    #1 btn_mode = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    model_btn(1'b1, 1'b0, 1'b0);
    check_state("enter");

    // Hours wrap both ways
    for (int k = 0; k < 6; k++) push_btn(1'b0, 1'b0, 1'b1, 1);
    check("hr.dec_to_23", 32'(edit_value), 23);
    push_btn(1'b0, 1'b1, 1'b0, 2);
    check("hr.inc_wrap", 32'(edit_value), 0);
    push_btn(1'b0, 1'b0, 1'b1, 1);
    check("hr.dec_wrap", 32'(edit_value), 23);
    check_state("hrwrap");

    // Finish this pass, then a full pass with known values
    repeat (3) push_btn(1'b1, 1'b0, 1'b0, 1);
    check_state("pass0");
    q_hours = 5'd12; q_minutes = 6'd34; q_seconds = 6'd56;
    repeat (4) push_btn(1'b1, 1'b0, 1'b0, 1);
    check("pass.nw", 32'(got_w.size()), 3);
    if (got_w.size() == 3) begin
      check("pass.w0", 32'(got_w[0]), 32'({2'b10, 6'd12}));
      check("pass.w1", 32'(got_w[1]), 32'({2'b01, 6'd34}));
      check("pass.w2", 32'(got_w[2]), 32'({2'b00, 6'd56}));
    end
    check_state("pass");

    // Timeout in ED_MIN after committing hours
    q_hours = 5'(($urandom % 24)); q_minutes = 6'(($urandom % 60));
    push_btn(1'b1, 1'b0, 1'b0, 1);
    push_btn(1'b1, 1'b0, 1'b0, 1);
    tick();
    tick();
    check_state("to.pre");
    tick();
    check("to.field", 32'(edit_field), 3);
    check_state("to.post");

    // mode+inc in ED_SEC at 59
    q_seconds = 6'd59;
    repeat (3) push_btn(1'b1, 1'b0, 1'b0, 1);
    check("sec.val", 32'(edit_value), 59);
    push_btn(1'b1, 1'b1, 1'b0, 1);
    check("sec.field", 32'(edit_field), 3);
    check_state("modeinc");

    // inc+dec together ignored; held inc gives one step
    q_hours = 5'd7;
    push_btn(1'b1, 1'b0, 1'b0, 1);
    push_btn(1'b0, 1'b1, 1'b1, 2);
    check("incdec.val", 32'(edit_value), 7);
    push_btn(1'b0, 1'b1, 1'b0, 100);
    check("held.val", 32'(edit_value), 8);
    check_state("held");

    // Random operations
    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 5);
      q_hours   = 5'($urandom % 24);
      q_minutes = 6'($urandom % 60);
      q_seconds = 6'($urandom % 60);
      case (op)
        0: push_btn(1'b1, 1'b0, 1'b0, $urandom_range(1, 3));
        1: push_btn(1'b0, 1'b1, 1'b0, $urandom_range(1, 3));
        2: push_btn(1'b0, 1'b0, 1'b1, $urandom_range(1, 3));
        3: tick();
        4: push_btn(1'b1, 1'($urandom), 1'($urandom), 1);
        default: push_btn(1'b0, 1'b1, 1'b1, 1);
      endcase
      check_state("rand");
    end

    // Reset mid-edit in ED_MIN with a mode press in flight
    if (m_field != 3) begin
      repeat (3) push_btn(1'b1, 1'b0, 1'b0, 1);
      if (m_field != 3) push_btn(1'b1, 1'b0, 1'b0, 1);
    end
    push_btn(1'b1, 1'b0, 1'b0, 1);
    push_btn(1'b1, 1'b0, 1'b0, 1);
    check("rst.in_min", 32'(edit_field), 1);
    check_state("rst.pre");
    @(posedge clk); #1 btn_mode = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check_reset_outputs("rst.async");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1 btn_mode = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    m_field = 3; m_val = 0; m_blink = 0; m_to = 0;
    m_last_addr = 0; m_last_data = 0;
    check_state("rst.post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
